// File: rtl/mat_pkg.sv
// Shared types and helpers for the matrix datapath sequencers.
package mat_pkg;

  typedef enum logic {LOAD, DRAIN} tp_state_t;

  // Default element width of the matrix datapath (signed fixed-point, opaque here).
  localparam int ELEM_BITS = 22;
  typedef logic [ELEM_BITS-1:0] elem_t;

  // Index width for a dimension of n entries; a size-1 dimension still gets one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/transpose_stream_ctrl_if.sv
// Element stream handshake bundle: input side (producer) and output side (consumer).
interface transpose_stream_ctrl_if #(
  parameter int N_BITS = 22
);
  logic [N_BITS-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [N_BITS-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_row_last;
  logic              out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_row_last, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_row_last, out_last
  );
endinterface

// File: rtl/wrap_counter_2d.sv
// Row/column index pair walking a ROWS x COLS grid in row-major order.
// Column advances on en, wraps into the next row; the whole pair wraps to 0
// after the last cell. clr has priority over en.
module wrap_counter_2d
  import mat_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int RW = clog2_min1(ROWS),
  localparam int CW = clog2_min1(COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          col_last,
  output logic          last
);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  // Next-index computation with wrap at the end of each row and of the grid.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (en) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row      = row_q;
  assign col      = col_q;
  assign col_last = (col_q == COL_MAX);
  assign last     = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/transpose_stream_ctrl.sv
// Streaming transposer: loads a SIZE_A x SIZE_B matrix row-major into a local
// buffer, then replays it column-major (the SIZE_B x SIZE_A transpose, row-major).
// Single buffer, so load and drain never overlap.
module transpose_stream_ctrl
  import mat_pkg::*;
#(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int N_BITS = 22
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  output logic                    busy,
  transpose_stream_ctrl_if.slave  bus
);

  localparam int AW = clog2_min1(SIZE_A);
  localparam int BW = clog2_min1(SIZE_B);

  tp_state_t state_q, state_d;

  logic [N_BITS-1:0] mem_q [SIZE_A][SIZE_B];
  logic [N_BITS-1:0] mem_d [SIZE_A][SIZE_B];

  // Load walks r (0..SIZE_A-1) / c (0..SIZE_B-1); drain walks i (0..SIZE_B-1) / j (0..SIZE_A-1).
  logic [AW-1:0] ld_r;
  logic [BW-1:0] ld_c;
  logic          ld_col_last, ld_last;
  logic [BW-1:0] dr_i;
  logic [AW-1:0] dr_j;
  logic          dr_col_last, dr_last;

  logic in_ready, out_valid, ld_fire, dr_fire;

  assign in_ready  = (state_q == LOAD)  && !clear;
  assign out_valid = (state_q == DRAIN) && !clear;
  assign ld_fire   = bus.in_valid && in_ready;
  assign dr_fire   = out_valid && bus.out_ready;

  wrap_counter_2d #(.ROWS(SIZE_A), .COLS(SIZE_B)) u_load_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clear),
    .en       (ld_fire),
    .row      (ld_r),
    .col      (ld_c),
    .col_last (ld_col_last),
    .last     (ld_last)
  );

  wrap_counter_2d #(.ROWS(SIZE_B), .COLS(SIZE_A)) u_drain_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clear),
    .en       (dr_fire),
    .row      (dr_i),
    .col      (dr_j),
    .col_last (dr_col_last),
    .last     (dr_last)
  );

  // Phase sequencing: clear forces LOAD; the final handshake of each phase flips it.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD:    if (ld_fire && ld_last) state_d = DRAIN;
        DRAIN:   if (dr_fire && dr_last) state_d = LOAD;
        default: state_d = LOAD;
      endcase
    end
  end

  // Phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  // Buffer write of the accepted element at its row-major position.
  always_comb begin
    mem_d = mem_q;
    if (ld_fire) mem_d[ld_r][ld_c] = bus.in_data;
  end

  // Buffer storage; only reset clears it, clear leaves stale data to be overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < SIZE_A; a++) begin
        for (int b = 0; b < SIZE_B; b++) begin
          mem_q[a][b] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Output mux is driven only by registered indices, so data holds through stalls.
  assign bus.out_data     = (state_q == DRAIN) ? mem_q[dr_j][dr_i] : '0;
  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_row_last = out_valid && dr_col_last;
  assign bus.out_last     = out_valid && dr_last;

  // A partial load shows up as nonzero load indices while still in LOAD.
  assign busy = (state_q == DRAIN) || (ld_r != '0) || (ld_c != '0);

endmodule

// File: tb/tb_transpose_stream_ctrl.sv
// Bench for transpose_stream_ctrl: a 2x3 and an 8x8 instance share clock and
// reset; 'sel' steers stimulus to one of them and picks which one is observed.
module tb_transpose_stream_ctrl;
  import mat_pkg::*;

  logic  clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst_n;
  logic  sel;
  elem_t in_data;
  logic  in_valid, out_ready, clear;
  logic  busy_s, busy_b;

  transpose_stream_ctrl_if #(.N_BITS(ELEM_BITS)) if_s ();
  transpose_stream_ctrl_if #(.N_BITS(ELEM_BITS)) if_b ();

  assign if_s.in_data   = in_data;
  assign if_b.in_data   = in_data;
  assign if_s.in_valid  = in_valid & ~sel;
  assign if_b.in_valid  = in_valid & sel;
  assign if_s.out_ready = out_ready;
  assign if_b.out_ready = out_ready;

  transpose_stream_ctrl #(.SIZE_A(2), .SIZE_B(3), .N_BITS(ELEM_BITS)) u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear & ~sel),
    .busy  (busy_s),
    .bus   (if_s.slave)
  );

  transpose_stream_ctrl #(.SIZE_A(8), .SIZE_B(8), .N_BITS(ELEM_BITS)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear & sel),
    .busy  (busy_b),
    .bus   (if_b.slave)
  );

  logic  o_valid, o_in_ready, o_row_last, o_last, o_busy;
  elem_t o_data;
  assign o_valid    = sel ? if_b.out_valid    : if_s.out_valid;
  assign o_in_ready = sel ? if_b.in_ready     : if_s.in_ready;
  assign o_row_last = sel ? if_b.out_row_last : if_s.out_row_last;
  assign o_last     = sel ? if_b.out_last     : if_s.out_last;
  assign o_busy     = sel ? busy_b            : busy_s;
  assign o_data     = sel ? if_b.out_data     : if_s.out_data;

  int    n_assert = 0;
  int    n_fail   = 0;
  int    sa, sb;
  elem_t in_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present in_q[0..n-1] with random idle gaps; entered and left at a negedge.
  task automatic load_matrix(input int n, input int gap_pct);
    for (int k = 0; k < n; k++) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = in_q[k];
      #1;
      check("in_ready_load", o_in_ready, 1);
      check("out_valid_load", o_valid, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Consume max_out outputs; mode 0 = always ready, 1 = toggle, 2 = random.
  task automatic drain(input int mode, input int max_out, input bit check_entry);
    int    k = 0;
    int    cyc = 0;
    int    total = sa * sb;
    int    budget = 20 * total + 100;
    bit    prev_stall = 1'b0;
    elem_t prev_exp = '0;
    elem_t exp;
    while (k < max_out && cyc < budget) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(1));
      endcase
      #1;
      if (cyc == 0 && check_entry) check("out_valid_first", o_valid, 1);
      if (prev_stall) check("data_stable", o_data, prev_exp);
      check("out_valid_drain", o_valid, 1);
      if (o_valid === 1'b1) begin
        exp = in_q[(k % sa) * sb + k / sa];
        check("out_data", o_data, exp);
        check("out_row_last", o_row_last, (k % sa == sa - 1));
        check("out_last", o_last, (k == total - 1));
        check("busy_drain", o_busy, 1);
        prev_stall = !out_ready;
        prev_exp   = exp;
        if (out_ready) k++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (k < max_out) check("drain_timeout", k, max_out);
    if (max_out == total) begin
      #1;
      check("in_ready_after", o_in_ready, 1);
      check("out_valid_after", o_valid, 0);
      check("busy_after", o_busy, 0);
    end
  endtask

  task automatic fill_seq(input int n, input int base);
    in_q.delete();
    for (int k = 0; k < n; k++) in_q.push_back(elem_t'(base + k));
  endtask

  task automatic fill_rand(input int n);
    in_q.delete();
    for (int k = 0; k < n; k++) in_q.push_back(elem_t'($urandom));
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; in_data = '0; in_valid = 1'b0;
    out_ready = 1'b0; clear = 1'b0;
    sa = 2; sb = 3;

    // Reset values
    #12;
    check("rst_out_valid_s", if_s.out_valid, 0);
    check("rst_out_valid_b", if_b.out_valid, 0);
    check("rst_out_last", if_s.out_last, 0);
    check("rst_row_last", if_s.out_row_last, 0);
    check("rst_out_data", if_b.out_data, 0);
    check("rst_busy", busy_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready_s", if_s.in_ready, 1);
    check("rst_in_ready_b", if_b.in_ready, 1);
    @(negedge clk);

    // 2x3 back-to-back, always ready: 1,4,2,5,3,6
    fill_seq(6, 1);
    load_matrix(6, 0);
    drain(0, 6, 1);

    // Same matrix, consumer toggling ready
    load_matrix(6, 0);
    drain(1, 6, 1);

    // clear after a partial load; the element offered with clear is dropped
    fill_seq(3, 1);
    load_matrix(3, 0);
    #1;
    check("busy_partial", o_busy, 1);
    clear = 1'b1; in_valid = 1'b1; in_data = elem_t'(99);
    #1;
    check("in_ready_clear", o_in_ready, 0);
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    #1;
    check("busy_after_clear", o_busy, 0);
    check("in_ready_after_clear", o_in_ready, 1);
    fill_seq(6, 10);
    load_matrix(6, 0);
    drain(0, 6, 1);

    // clear during drain after two outputs
    fill_rand(6);
    load_matrix(6, 0);
    drain(0, 2, 1);
    clear = 1'b1; out_ready = 1'b1;
    #1;
    check("out_valid_in_clear", o_valid, 0);
    @(negedge clk);
    clear = 1'b0; out_ready = 1'b0;
    #1;
    check("out_valid_post_clear", o_valid, 0);
    check("in_ready_post_clear", o_in_ready, 1);
    check("busy_post_clear", o_busy, 0);
    fill_rand(6);
    load_matrix(6, 20);
    drain(2, 6, 1);

    // 8x8 with random gaps on both sides, two matrices in a row
    sel = 1'b1; sa = 8; sb = 8;
    @(negedge clk);
    fill_seq(64, 0);
    load_matrix(64, 30);
    drain(2, 64, 1);
    fill_rand(64);
    load_matrix(64, 30);
    drain(2, 64, 1);

    // Asynchronous reset in the middle of a drain
    fill_rand(64);
    load_matrix(64, 0);
    drain(0, 5, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", o_valid, 0);
    check("async_rst_out_data", o_data, 0);
    check("async_rst_busy", o_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", o_in_ready, 1);
    check("post_rst_out_data", o_data, 0);
    check("post_rst_out_valid", o_valid, 0);
    @(negedge clk);
    fill_rand(64);
    load_matrix(64, 10);
    drain(2, 64, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
